// File: rtl/tile_click_decoder_if.sv
// Mouse/tile-click bundle between the pointer front end and the flip logic.
// master = stimulus/producer side (drives mouse + lock, reads click/hover),
// slave  = tile_click_decoder.
interface tile_click_decoder_if;
    logic        mouse_left;
    logic [11:0] xpos;
    logic [11:0] ypos;
    logic        lock;
    logic        click_valid;
    logic [2:0]  click_col;
    logic [2:0]  click_row;
    logic [5:0]  click_idx;
    logic        hover_valid;
    logic [5:0]  hover_idx;

    modport master (
        output mouse_left, xpos, ypos, lock,
        input  click_valid, click_col, click_row, click_idx, hover_valid, hover_idx
    );

    modport slave (
        input  mouse_left, xpos, ypos, lock,
        output click_valid, click_col, click_row, click_idx, hover_valid, hover_idx
    );
endinterface

// File: rtl/tile_click_decoder.sv
// Tile click decoder: synchronises the left mouse button, hit-tests the
// pointer against a ROWS x COLS grid and emits a one-cycle click event when
// press and release land on the same tile.
// Optional build macro TILE_CLICK_DEBOUNCE_EN adds a DEBOUNCE_CYCLES filter
// on the synchronised button; without it the button is used as synchronised.
module tile_click_decoder #(
    parameter logic [11:0] X0              = 12'd128,
    parameter logic [11:0] Y0              = 12'd96,
    parameter logic [11:0] TILE_W          = 12'd96,
    parameter logic [11:0] TILE_H          = 12'd96,
    parameter logic [11:0] GAP             = 12'd16,
    parameter int          COLS            = 4,
    parameter int          ROWS            = 4,
    parameter int          DEBOUNCE_CYCLES = 65000
) (
    input  logic                clk,
    input  logic                rst,
    tile_click_decoder_if.slave bus
);

    if (COLS < 1 || COLS > 8 || ROWS < 1 || ROWS > 8 || DEBOUNCE_CYCLES < 1) begin : g_bad_cfg
        $error("tile_click_decoder: COLS/ROWS must be 1..8 and DEBOUNCE_CYCLES >= 1");
    end

    localparam int PITCH_X = int'(TILE_W) + int'(GAP);
    localparam int PITCH_Y = int'(TILE_H) + int'(GAP);

    typedef enum logic [1:0] {IDLE, ARMED, IGNORE} state_t;

    logic       sync1_q, btn_s_q, btn, btn_d_q;
    logic       press_q, rel_q;
    logic       hit_d, hit_q;
    logic [2:0] col_d, row_d, hit_col_q, hit_row_q;
    logic [5:0] idx_d, hit_idx_q, armed_idx_q;
    state_t     state_q;
    logic       click_valid_q;
    logic [2:0] click_col_q, click_row_q;
    logic [5:0] click_idx_q;

    // Two-flop synchroniser for the asynchronous button
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            btn_s_q <= 1'b0;
        end else begin
            sync1_q <= bus.mouse_left;
            btn_s_q <= sync1_q;
        end
    end

`ifdef TILE_CLICK_DEBOUNCE_EN
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    logic          btn_q;
    logic [CW-1:0] cnt_q;

    // Follow btn_s only after it has disagreed for DEBOUNCE_CYCLES straight cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_q <= 1'b0;
            cnt_q <= '0;
        end else if (btn_s_q == btn_q) begin
            cnt_q <= '0;
        end else if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
            btn_q <= btn_s_q;
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end
    assign btn = btn_q;
`else
    assign btn = btn_s_q;
`endif

    // Edge detect, registered so FSM sees clean one-cycle press/release pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_d_q <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            btn_d_q <= btn;
            press_q <= btn & ~btn_d_q;
            rel_q   <= ~btn & btn_d_q;
        end
    end

    // Per-axis window compare against each tile span (no divide)
    always_comb begin
        int  dx, dy;
        logic cx, cy;
        cx    = 1'b0;
        cy    = 1'b0;
        col_d = '0;
        row_d = '0;
        dx    = int'(bus.xpos) - int'(X0);
        dy    = int'(bus.ypos) - int'(Y0);
        for (int c = 0; c < COLS; c++) begin
            if (bus.xpos >= X0 && dx >= c * PITCH_X && dx <= c * PITCH_X + int'(TILE_W) - 1) begin
                cx    = 1'b1;
                col_d = 3'(c);
            end
        end
        for (int r = 0; r < ROWS; r++) begin
            if (bus.ypos >= Y0 && dy >= r * PITCH_Y && dy <= r * PITCH_Y + int'(TILE_H) - 1) begin
                cy    = 1'b1;
                row_d = 3'(r);
            end
        end
        hit_d = cx & cy;
        idx_d = hit_d ? 6'(int'(row_d) * COLS + int'(col_d)) : 6'd0;
    end

    // Register the hit result; doubles as the hover output
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_q     <= 1'b0;
            hit_col_q <= '0;
            hit_row_q <= '0;
            hit_idx_q <= '0;
        end else begin
            hit_q     <= hit_d;
            hit_col_q <= col_d;
            hit_row_q <= row_d;
            hit_idx_q <= idx_d;
        end
    end

    // Click FSM: arm on a valid press, fire on release over the same tile
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            armed_idx_q   <= '0;
            click_valid_q <= 1'b0;
            click_col_q   <= '0;
            click_row_q   <= '0;
            click_idx_q   <= '0;
        end else begin
            click_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (press_q) begin
                        if (hit_q && !bus.lock) begin
                            armed_idx_q <= hit_idx_q;
                            state_q     <= ARMED;
                        end else begin
                            state_q <= IGNORE;
                        end
                    end
                end
                ARMED: begin
                    // lock beats a simultaneous release; that release still ends the gesture
                    if (bus.lock) begin
                        state_q <= rel_q ? IDLE : IGNORE;
                    end else if (rel_q) begin
                        if (hit_q && hit_idx_q == armed_idx_q) begin
                            click_valid_q <= 1'b1;
                            click_col_q   <= hit_col_q;
                            click_row_q   <= hit_row_q;
                            click_idx_q   <= hit_idx_q;
                        end
                        state_q <= IDLE;
                    end
                end
                IGNORE: begin
                    if (rel_q) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.click_valid = click_valid_q;
    assign bus.click_col   = click_col_q;
    assign bus.click_row   = click_row_q;
    assign bus.click_idx   = click_idx_q;
    assign bus.hover_valid = hit_q;
    assign bus.hover_idx   = hit_idx_q;

endmodule

// File: tb/tb_tile_click_decoder.sv
// Scoreboard bench for tile_click_decoder: expected clicks are queued when a
// release is driven and compared when click_valid fires.
module tb_tile_click_decoder;

`ifdef TILE_CLICK_DEBOUNCE_EN
    localparam int DB = 8;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = 4 + DB;
    localparam int W   = 10 + DB;

    typedef struct {
        int idx;
        int row;
        int col;
        int cyc;   // expected pulse cycle, -1 = latency not checked
    } exp_t;

    logic clk, rst;
    tile_click_decoder_if bus();

    tile_click_decoder #(.DEBOUNCE_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    exp_t sb[$];
    int   n_chk, n_pass, cyc, prev_v;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic move(input int x, input int y);
        bus.xpos = 12'(x);
        bus.ypos = 12'(y);
    endtask

    task automatic push(input int idx, input int row, input int col, input int c);
        exp_t e;
        e.idx = idx; e.row = row; e.col = col; e.cyc = c;
        sb.push_back(e);
    endtask

    // Monitor: pop expected click on every pulse
    always @(negedge clk) begin
        if (!rst && bus.click_valid) begin
            chk("no_double", prev_v, 0);
            if (sb.size() == 0) begin
                chk("unexpected_click", 1, 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("click_idx", int'(bus.click_idx), e.idx);
                chk("click_row", int'(bus.click_row), e.row);
                chk("click_col", int'(bus.click_col), e.col);
                if (e.cyc >= 0) chk("click_lat", cyc, e.cyc);
            end
        end
        prev_v = int'(bus.click_valid);
    end

    initial begin
        n_chk = 0; n_pass = 0; cyc = 0; prev_v = 0;
        rst = 1'b1;
        bus.mouse_left = 1'b0;
        bus.lock = 1'b0;
        move(0, 0);
        wait_cyc(3);
        chk("rst_click_valid", int'(bus.click_valid), 0);
        chk("rst_click_idx",   int'(bus.click_idx), 0);
        chk("rst_hover_valid", int'(bus.hover_valid), 0);
        rst = 1'b0;
        wait_cyc(2);

        // 1: press/release inside tile 0, latency check
        move(130, 100); wait_cyc(2);
        chk("hover_t0_valid", int'(bus.hover_valid), 1);
        chk("hover_t0_idx",   int'(bus.hover_idx), 0);
        bus.mouse_left = 1'b1; wait_cyc(W);
        move(200, 150); wait_cyc(2);
        push(0, 0, 0, cyc + LAT);
        bus.mouse_left = 1'b0; wait_cyc(W);

        // 2: press col 1, release col 0 -> nothing
        move(250, 100); wait_cyc(2);
        chk("hover_t1_idx", int'(bus.hover_idx), 1);
        bus.mouse_left = 1'b1; wait_cyc(W);
        move(130, 100); wait_cyc(2);
        bus.mouse_left = 1'b0; wait_cyc(W);

        // 3: press in gap -> ignored even if released on a tile
        move(224, 100); wait_cyc(2);
        chk("hover_gap_valid", int'(bus.hover_valid), 0);
        chk("hover_gap_idx",   int'(bus.hover_idx), 0);
        bus.mouse_left = 1'b1; wait_cyc(W);
        move(130, 100); wait_cyc(2);
        bus.mouse_left = 1'b0; wait_cyc(W);

        // grid edges: past last column and left of origin are misses
        move(560, 100); wait_cyc(2);
        chk("hover_beyond", int'(bus.hover_valid), 0);
        move(127, 100); wait_cyc(2);
        chk("hover_left", int'(bus.hover_valid), 0);
        move(559, 527); wait_cyc(2);
        chk("hover_corner_idx", int'(bus.hover_idx), 15);

        // 4: lock while armed kills the click; retry unlocked gives idx 15
        move(480, 460); wait_cyc(2);
        chk("hover_t15_idx", int'(bus.hover_idx), 15);
        bus.mouse_left = 1'b1; wait_cyc(W);
        bus.lock = 1'b1; wait_cyc(2);
        bus.mouse_left = 1'b0; wait_cyc(W);
        bus.lock = 1'b0; wait_cyc(2);
        bus.mouse_left = 1'b1; wait_cyc(W);
        push(15, 3, 3, -1);
        bus.mouse_left = 1'b0; wait_cyc(W);

        // press while locked -> ignored
        bus.lock = 1'b1;
        bus.mouse_left = 1'b1; wait_cyc(W);
        bus.lock = 1'b0;
        bus.mouse_left = 1'b0; wait_cyc(W);

        // 5: short pulse: filtered with debounce, a real click without
        move(130, 100); wait_cyc(2);
        bus.mouse_left = 1'b1; wait_cyc(5);
`ifndef TILE_CLICK_DEBOUNCE_EN
        push(0, 0, 0, -1);
`endif
        bus.mouse_left = 1'b0; wait_cyc(W + 10);
        bus.mouse_left = 1'b1; wait_cyc(20);
        push(0, 0, 0, -1);
        bus.mouse_left = 1'b0; wait_cyc(W + 10);

        // 6: reset while held over tile 5, then release there
        move(250, 220); wait_cyc(2);
        chk("hover_t5_idx", int'(bus.hover_idx), 5);
        bus.mouse_left = 1'b1; wait_cyc(W);
        rst = 1'b1; wait_cyc(1);
        chk("midrst_click_idx",   int'(bus.click_idx), 0);
        chk("midrst_hover_valid", int'(bus.hover_valid), 0);
        chk("midrst_click_valid", int'(bus.click_valid), 0);
        rst = 1'b0; wait_cyc(W);
        push(5, 1, 1, -1);
        bus.mouse_left = 1'b0; wait_cyc(W);

        chk("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
